// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared widths, fetch-state encoding and instruction field positions.
// Exposes PC_W/INSTR_W, the FETCH/HALT state enum, the bit positions of the
// format/opcode/sign/operand fields, and a field-consistency helper.
package instr_fetch_pkg;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 9;

   localparam int FMT_BIT = 8;
   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 4;
   localparam int SGN_BIT = 3;
   localparam int OPR_MSB = 2;

   typedef enum logic {
      FETCH = 1'b0,
      HALT  = 1'b1
   } fetch_state_e;

   // The ROM exposes the low byte twice: once whole, once split into fields.
   // Both views must describe the same bits.
   function automatic logic fields_match(
      input logic [OPC_MSB:0]         imm,
      input logic [OPC_MSB-OPC_LSB:0] opc,
      input logic                     sgn,
      input logic [OPR_MSB:0]         opr
   );
      return imm == {opc, sgn, opr};
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: program-counter sequencer with a one-entry instruction register.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   pc_out                - address presented to the combinational program ROM
//   rom_format/opcode/sign/operand/immediate - ROM fields of the word at pc_out
//   ir_valid/ir_ready     - handshake for ir_instr/ir_pc towards decode
//   ir_instr, ir_pc       - captured instruction word and its fetch address
//   br_take, br_target    - single-cycle redirect (flushes the instruction register)
//   halt_req              - stop fetching
//   halted                - block is in HALT
//   field_err             - sticky flag for inconsistent ROM fields
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [PC_W-1:0] START_PC = 16'd0,
   parameter logic [PC_W-1:0] LAST_PC  = 16'd34
) (
   input  logic                   clk,
   input  logic                   reset,
   output logic [PC_W-1:0]        pc_out,
   input  logic                   rom_format,
   input  logic [OPC_MSB-OPC_LSB:0] rom_opcode,
   input  logic                   rom_sign,
   input  logic [OPR_MSB:0]       rom_operand,
   input  logic [OPC_MSB:0]       rom_immediate,
   output logic                   ir_valid,
   input  logic                   ir_ready,
   output logic [INSTR_W-1:0]     ir_instr,
   output logic [PC_W-1:0]        ir_pc,
   input  logic                   br_take,
   input  logic [PC_W-1:0]        br_target,
   input  logic                   halt_req,
   output logic                   halted,
   output logic                   field_err
);

   fetch_state_e         state_q, state_d;
   logic [PC_W-1:0]      pc_q, pc_d;
   logic                 valid_q, valid_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [PC_W-1:0]      irpc_q, irpc_d;
   logic                 halted_q, halted_d;
   logic                 ferr_q, ferr_d;
   logic                 capture, redirect;

   always_comb begin
      // A redirect wins over capture so the word at the stale pc_out is dropped.
      redirect = (state_q == FETCH) && br_take;
      capture  = (state_q == FETCH) && (!valid_q || ir_ready) && !br_take;
      pc_d     = redirect ? br_target : capture ? pc_q + 16'd1 : pc_q;
      valid_d  = redirect ? 1'b0 : capture ? 1'b1 : valid_q && !ir_ready;
      instr_d  = capture ? {rom_format, rom_immediate} : instr_q;
      irpc_d   = capture ? pc_q : irpc_q;
      state_d  = (state_q == FETCH && (halt_req || (capture && pc_q == LAST_PC))) ? HALT : state_q;
      halted_d = state_d == HALT;
      ferr_d   = ferr_q || (capture && !fields_match(rom_immediate, rom_opcode, rom_sign, rom_operand));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= FETCH;
         pc_q     <= START_PC;
         valid_q  <= 1'b0;
         instr_q  <= '0;
         irpc_q   <= '0;
         halted_q <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         irpc_q   <= irpc_d;
         halted_q <= halted_d;
         ferr_q   <= ferr_d;
      end
   end

   assign pc_out    = pc_q;
   assign ir_valid  = valid_q;
   assign ir_instr  = instr_q;
   assign ir_pc     = irpc_q;
   assign halted    = halted_q;
   assign field_err = ferr_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a program ROM and a wrap/field-error stub.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   typedef struct packed {
      logic [8:0]  instr;
      logic [15:0] pc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1, ir_ready = 1'b0, br_take = 1'b0, halt_req = 1'b0;
   logic [15:0] br_target = 16'd0;
   logic [15:0] pc_out, ir_pc;
   logic [8:0]  ir_instr, rom_w;
   logic        ir_valid, halted, field_err;
   logic [43:0] obs;

   logic        w_reset = 1'b1, w_ready = 1'b0;
   logic [15:0] w_pc, w_irpc;
   logic [8:0]  w_instr;
   logic        w_valid, w_halted, w_ferr;

   exp_t q[$];
   exp_t e;
   int   vectors = 0, miscompares = 0;

   function automatic logic [8:0] rom_word(input logic [15:0] a);
      case (a)
         16'd0:   return 9'h001;
         16'd1:   return 9'h110;
         16'd2:   return 9'h01F;
         16'd5:   return 9'h101;
         16'd6:   return 9'h179;
         16'd20:  return 9'h112;
         16'd34:  return 9'h125;
         default: return a > 16'd34 ? 9'h000 : {a[1], a[7:0] ^ 8'h3C};
      endcase
   endfunction

   assign rom_w = rom_word(pc_out);
   assign obs   = {ir_valid, ir_instr, ir_pc, pc_out, halted, field_err};

   instr_fetch dut (
      .clk(clk), .reset(reset), .pc_out(pc_out),
      .rom_format(rom_w[8]), .rom_opcode(rom_w[7:4]), .rom_sign(rom_w[3]),
      .rom_operand(rom_w[2:0]), .rom_immediate(rom_w[7:0]),
      .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_instr(ir_instr), .ir_pc(ir_pc),
      .br_take(br_take), .br_target(br_target), .halt_req(halt_req),
      .halted(halted), .field_err(field_err)
   );

   instr_fetch #(.START_PC(16'hFFFF)) dut_wrap (
      .clk(clk), .reset(w_reset), .pc_out(w_pc),
      .rom_format(1'b0), .rom_opcode(4'hF), .rom_sign(1'b0),
      .rom_operand(3'd0), .rom_immediate(8'h5A),
      .ir_valid(w_valid), .ir_ready(w_ready), .ir_instr(w_instr), .ir_pc(w_irpc),
      .br_take(1'b0), .br_target(16'd0), .halt_req(1'b0),
      .halted(w_halted), .field_err(w_ferr)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; ir_ready = 1'b0; br_take = 1'b0; halt_req = 1'b0;
      step();
      reset = 1'b0;
      vectors++;
      if (obs !== {1'b0, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
         miscompares++; $display("FAIL reset_state: got %h want %h", obs, {1'b0, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0});
      end
   endtask

   task automatic test_stream();
      ir_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         q.push_back({rom_word(16'(i)), 16'(i)});
         step();
         vectors++;
         if (q.size() == 0) begin
            miscompares++; $display("FAIL stream_pop: scoreboard empty");
         end else begin
            e = q.pop_front();
            if ({ir_valid, ir_instr, ir_pc} !== {1'b1, e}) begin
               miscompares++; $display("FAIL stream_%0d: got %h want %h", i, {ir_valid, ir_instr, ir_pc}, {1'b1, e});
            end
         end
      end
      vectors++;
      if (obs !== {1'b1, 9'h01F, 16'd2, 16'd3, 1'b0, 1'b0}) begin
         miscompares++; $display("FAIL stream_end: got %h want %h", obs, {1'b1, 9'h01F, 16'd2, 16'd3, 1'b0, 1'b0});
      end
   endtask

   task automatic test_stall();
      ir_ready = 1'b1;
      for (int i = 3; i < 6; i++) begin
         q.push_back({rom_word(16'(i)), 16'(i)});
         step();
         vectors++;
         e = q.pop_front();
         if ({ir_valid, ir_instr, ir_pc} !== {1'b1, e}) begin
            miscompares++; $display("FAIL stall_fill_%0d: got %h want %h", i, {ir_valid, ir_instr, ir_pc}, {1'b1, e});
         end
      end
      ir_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         vectors++;
         if (obs !== {1'b1, 9'h101, 16'd5, 16'd6, 1'b0, 1'b0}) begin
            miscompares++; $display("FAIL stall_hold_%0d: got %h want %h", i, obs, {1'b1, 9'h101, 16'd5, 16'd6, 1'b0, 1'b0});
         end
      end
      ir_ready = 1'b1;
      q.push_back({9'h179, 16'd6});
      step();
      vectors++;
      e = q.pop_front();
      if ({ir_valid, ir_instr, ir_pc, pc_out} !== {1'b1, e, 16'd7}) begin
         miscompares++; $display("FAIL stall_release: got %h want %h", {ir_valid, ir_instr, ir_pc, pc_out}, {1'b1, e, 16'd7});
      end
   endtask

   task automatic test_branch();
      ir_ready = 1'b1;
      q.push_back({rom_word(16'd7), 16'd7});
      step();
      ir_ready = 1'b0;
      vectors++;
      e = q.pop_front();
      if ({ir_valid, ir_instr, ir_pc} !== {1'b1, e}) begin
         miscompares++; $display("FAIL branch_pre: got %h want %h", {ir_valid, ir_instr, ir_pc}, {1'b1, e});
      end
      step();
      br_take = 1'b1; br_target = 16'd20;
      step();
      br_take = 1'b0;
      vectors++;
      if (obs !== {1'b0, rom_word(16'd7), 16'd7, 16'd20, 1'b0, 1'b0}) begin
         miscompares++; $display("FAIL branch_flush: got %h want %h", obs, {1'b0, rom_word(16'd7), 16'd7, 16'd20, 1'b0, 1'b0});
      end
      q.push_back({9'h112, 16'd20});
      step();
      vectors++;
      e = q.pop_front();
      if ({ir_valid, ir_instr, ir_pc, pc_out} !== {1'b1, e, 16'd21}) begin
         miscompares++; $display("FAIL branch_target: got %h want %h", {ir_valid, ir_instr, ir_pc, pc_out}, {1'b1, e, 16'd21});
      end
   endtask

   task automatic test_run_to_last();
      ir_ready = 1'b1;
      for (int a = 21; a <= 34; a++) begin
         q.push_back({rom_word(16'(a)), 16'(a)});
         if (a == 34) ir_ready = 1'b1;
         step();
         vectors++;
         e = q.pop_front();
         if ({ir_valid, ir_instr, ir_pc} !== {1'b1, e}) begin
            miscompares++; $display("FAIL run_%0d: got %h want %h", a, {ir_valid, ir_instr, ir_pc}, {1'b1, e});
         end
      end
      ir_ready = 1'b0;
      vectors++;
      if (obs !== {1'b1, 9'h125, 16'd34, 16'd35, 1'b1, 1'b0}) begin
         miscompares++; $display("FAIL last_halt: got %h want %h", obs, {1'b1, 9'h125, 16'd34, 16'd35, 1'b1, 1'b0});
      end
      br_take = 1'b1; br_target = 16'd5;
      step();
      br_take = 1'b0;
      vectors++;
      if (obs !== {1'b1, 9'h125, 16'd34, 16'd35, 1'b1, 1'b0}) begin
         miscompares++; $display("FAIL halt_branch_ignored: got %h want %h", obs, {1'b1, 9'h125, 16'd34, 16'd35, 1'b1, 1'b0});
      end
      ir_ready = 1'b1;
      step();
      step();
      vectors++;
      if (obs !== {1'b0, 9'h125, 16'd34, 16'd35, 1'b1, 1'b0}) begin
         miscompares++; $display("FAIL halt_retire: got %h want %h", obs, {1'b0, 9'h125, 16'd34, 16'd35, 1'b1, 1'b0});
      end
      reset = 1'b1; halt_req = 1'b1; br_take = 1'b1;
      step();
      reset = 1'b0; halt_req = 1'b0; br_take = 1'b0; ir_ready = 1'b0;
      vectors++;
      if (obs !== {1'b0, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0}) begin
         miscompares++; $display("FAIL halt_reset: got %h want %h", obs, {1'b0, 9'h000, 16'h0000, 16'h0000, 1'b0, 1'b0});
      end
   endtask

   task automatic test_halt_req();
      ir_ready = 1'b1; halt_req = 1'b1;
      q.push_back({9'h001, 16'd0});
      step();
      halt_req = 1'b0; ir_ready = 1'b0;
      vectors++;
      e = q.pop_front();
      if (obs !== {1'b1, e, 16'd1, 1'b1, 1'b0}) begin
         miscompares++; $display("FAIL halt_req_capture: got %h want %h", obs, {1'b1, e, 16'd1, 1'b1, 1'b0});
      end
      ir_ready = 1'b1;
      step();
      vectors++;
      if (obs !== {1'b0, 9'h001, 16'd0, 16'd1, 1'b1, 1'b0}) begin
         miscompares++; $display("FAIL halt_req_idle: got %h want %h", obs, {1'b0, 9'h001, 16'd0, 16'd1, 1'b1, 1'b0});
      end
      test_reset();
      ir_ready = 1'b1;
      q.push_back({9'h001, 16'd0});
      step();
      vectors++;
      e = q.pop_front();
      if ({ir_valid, ir_instr, ir_pc} !== {1'b1, e}) begin
         miscompares++; $display("FAIL halt_br_pre: got %h want %h", {ir_valid, ir_instr, ir_pc}, {1'b1, e});
      end
      halt_req = 1'b1; br_take = 1'b1; br_target = 16'd12;
      step();
      halt_req = 1'b0; br_take = 1'b0;
      vectors++;
      if (obs !== {1'b0, 9'h001, 16'd0, 16'd12, 1'b1, 1'b0}) begin
         miscompares++; $display("FAIL halt_and_branch: got %h want %h", obs, {1'b0, 9'h001, 16'd0, 16'd12, 1'b1, 1'b0});
      end
      step();
      vectors++;
      if (obs !== {1'b0, 9'h001, 16'd0, 16'd12, 1'b1, 1'b0}) begin
         miscompares++; $display("FAIL halt_and_branch_hold: got %h want %h", obs, {1'b0, 9'h001, 16'd0, 16'd12, 1'b1, 1'b0});
      end
   endtask

   task automatic test_wrap_field_err();
      w_reset = 1'b1; w_ready = 1'b0;
      step();
      w_reset = 1'b0;
      vectors++;
      if ({w_valid, w_pc, w_halted, w_ferr} !== {1'b0, 16'hFFFF, 1'b0, 1'b0}) begin
         miscompares++; $display("FAIL wrap_reset: got %h want %h", {w_valid, w_pc, w_halted, w_ferr}, {1'b0, 16'hFFFF, 1'b0, 1'b0});
      end
      w_ready = 1'b1;
      q.push_back({9'h05A, 16'hFFFF});
      q.push_back({9'h05A, 16'h0000});
      for (int i = 0; i < 2; i++) begin
         step();
         vectors++;
         e = q.pop_front();
         if ({w_valid, w_instr, w_irpc, w_pc, w_ferr} !== {1'b1, e, 16'(i), 1'b1}) begin
            miscompares++; $display("FAIL wrap_capture_%0d: got %h want %h", i, {w_valid, w_instr, w_irpc, w_pc, w_ferr}, {1'b1, e, 16'(i), 1'b1});
         end
      end
      w_ready = 1'b0;
      repeat (3) step();
      vectors++;
      if (w_ferr !== 1'b1) begin
         miscompares++; $display("FAIL wrap_sticky: got %b want 1", w_ferr);
      end
      w_reset = 1'b1;
      step();
      w_reset = 1'b0;
      vectors++;
      if ({w_pc, w_ferr} !== {16'hFFFF, 1'b0}) begin
         miscompares++; $display("FAIL wrap_clear: got %h want %h", {w_pc, w_ferr}, {16'hFFFF, 1'b0});
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_branch();
      test_run_to_last();
      test_halt_req();
      test_wrap_field_err();
      vectors++;
      if (q.size() != 0) begin
         miscompares++; $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
